sha_block_feeder: RTL and testbench

//  Upstream of sha_message_schedule. Takes one 512-bit padded block per valid/ready handshake.

---
 rtl/sha_pkg.sv | 21 ++
 rtl/sha_word_buffer.sv | 31 +++
 rtl/sha_block_feeder.sv | 102 ++++++++++
 tb/tb_sha_block_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared types and constants for the SHA-256 message front end.
// Holds the word type, round/block sizes, the byte-swap helper and the
// feeder state encoding.
package sha_pkg;

    typedef logic [31:0] word_t;

    localparam int SHA_ROUNDS      = 64;
    localparam int SHA_BLOCK_WORDS = 16;

    // Reverse the byte order of one 32-bit word.
    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_RUN  = 1'b1
    } feed_state_t;

endpackage

// File: rtl/sha_word_buffer.sv
// sha_word_buffer: 16-word parallel-load shift register.
// A load captures a full 512-bit block (word 0 in the top 32 bits).
// Each shift moves every word one slot toward word 0 and zero-fills the tail.
// The buffer has no reset: its content is only meaningful after a load.
module sha_word_buffer
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  word0
);

    word_t words [SHA_BLOCK_WORDS];

    // Load takes priority over shift so a back-to-back block replaces the tail.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < SHA_BLOCK_WORDS; i++)
                words[i] <= block[511 - 32*i -: 32];
        end else if (shift) begin
            for (int i = 0; i < SHA_BLOCK_WORDS - 1; i++)
                words[i] <= words[i+1];
            words[SHA_BLOCK_WORDS-1] <= '0;
        end
    end

    assign word0 = words[0];

endmodule

// File: rtl/sha_block_feeder.sv
// sha_block_feeder: accepts one padded 512-bit block per handshake and
// streams it as 16 M words while stepping the message-schedule round counter
// through 0..63. w_valid_o/w_index_o/done_o are delayed one cycle to line up
// with the schedule's registered W output. Back-to-back blocks are accepted in
// the counter==63 cycle so the counter wraps with no idle cycle.
// Build option: define SHA_FEEDER_BSWAP_EN to byte-reverse each input word on
// load (little-endian block input). Undefined: words pass unchanged.
module sha_block_feeder
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    input  logic [511:0] block_i,
    output logic [5:0]   counter_o,
    output logic [31:0]  M_o,
    output logic         w_valid_o,
    output logic [5:0]   w_index_o,
    output logic         done_o
);

    localparam logic [5:0] LAST_ROUND = 6'(SHA_ROUNDS - 1);

    feed_state_t  state, state_nxt;
    logic [5:0]   cnt_p0, cnt_nxt;
    logic         accept;
    logic [511:0] load_block;
    word_t        word0;

    // Optional byte-order conversion of each word before it enters the buffer.
    always_comb begin
        load_block = '0;
        for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
`ifdef SHA_FEEDER_BSWAP_EN
            load_block[511 - 32*i -: 32] = bswap32(block_i[511 - 32*i -: 32]);
`else
            load_block[511 - 32*i -: 32] = block_i[511 - 32*i -: 32];
`endif
        end
    end

    sha_word_buffer u_buf (
        .clk   (clk),
        .load  (accept),
        .shift (state == FEED_RUN),
        .block (load_block),
        .word0 (word0)
    );

    // State and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FEED_IDLE;
            cnt_p0 <= '0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    // Next state: RUN persists until round 63, then re-enters RUN only on accept.
    // The counter steps every RUN cycle; its natural 63->0 wrap covers both exits.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            FEED_IDLE: begin
                if (accept) state_nxt = FEED_RUN;
            end
            FEED_RUN: begin
                cnt_nxt = cnt_p0 + 6'd1;
                if (cnt_p0 == LAST_ROUND && !accept) state_nxt = FEED_IDLE;
            end
            default: state_nxt = FEED_IDLE;
        endcase
    end

    // Handshake and schedule-side outputs; M is forced to zero outside RUN
    // because the buffer keeps stale words across reset.
    always_comb begin
        block_ready_o = !rst && (state == FEED_IDLE ||
                                 (state == FEED_RUN && cnt_p0 == LAST_ROUND));
        accept        = block_valid_i && block_ready_o;
        M_o           = (state == FEED_RUN) ? word0 : '0;
        counter_o     = cnt_p0;
    end

    // W-side status delayed one cycle to match the schedule's registered W.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid_o <= 1'b0;
            w_index_o <= '0;
            done_o    <= 1'b0;
        end else begin
            w_valid_o <= (state == FEED_RUN);
            w_index_o <= cnt_p0;
            done_o    <= (state == FEED_RUN) && (cnt_p0 == LAST_ROUND);
        end
    end

endmodule

// File: tb/tb_sha_block_feeder.sv
// tb_sha_block_feeder: directed bench for sha_block_feeder. Rebuilds the
// SHA-256 W16/W17 values from the observed M stream to confirm word order.
module tb_sha_block_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         block_valid_i;
    logic         block_ready_o;
    logic [511:0] block_i;
    logic [5:0]   counter_o;
    logic [31:0]  M_o;
    logic         w_valid_o;
    logic [5:0]   w_index_o;
    logic         done_o;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mw [64];
    logic [511:0] abc_blk, pat_blk;

    sha_block_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .block_valid_i (block_valid_i),
        .block_ready_o (block_ready_o),
        .block_i       (block_i),
        .counter_o     (counter_o),
        .M_o           (M_o),
        .w_valid_o     (w_valid_o),
        .w_index_o     (w_index_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] exp_word(input logic [511:0] blk, input int k);
        logic [31:0] w;
        if (k >= 16) return 32'h0;
        w = blk[511 - 32*k -: 32];
`ifdef SHA_FEEDER_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    // One isolated block: accept, then check 64 rounds plus the done cycle.
    // block_valid_i toggles with garbage data mid-run and must be ignored.
    task automatic run_block(input logic [511:0] blk, input bit is_abc);
        logic [31:0] w16, w17;
        block_i       = blk;
        block_valid_i = 1'b1;
        chk("ready_idle", 32'(block_ready_o), 32'h1);
        tick();
        block_valid_i = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            if (k < 64) begin
                chk("counter", 32'(counter_o), 32'(k));
                mw[k] = M_o;
                chk("m_word", M_o, exp_word(blk, k));
                chk("ready_run", 32'(block_ready_o), 32'(k == 63));
            end else begin
                chk("counter_idle", 32'(counter_o), 32'h0);
                chk("m_idle", M_o, 32'h0);
            end
            chk("w_valid", 32'(w_valid_o), 32'(k >= 1));
            if (k >= 1) chk("w_index", 32'(w_index_o), 32'(k - 1));
            chk("done", 32'(done_o), 32'(k == 64));
            if (k >= 1 && k <= 61) begin
                block_valid_i = (k % 2 == 1);
                block_i       = ~blk;
            end else begin
                block_valid_i = 1'b0;
                block_i       = blk;
            end
            tick();
        end
        if (is_abc) begin
            w16 = sig1(mw[14]) + mw[9]  + sig0(mw[1]) + mw[0];
            w17 = sig1(mw[15]) + mw[10] + sig0(mw[2]) + mw[1];
            chk("abc_w0",  mw[0], 32'h61626380);
            chk("abc_w16", w16,   32'h61626380);
            chk("abc_w17", w17,   32'h000F0000);
        end
    endtask

    initial begin
`ifdef SHA_FEEDER_BSWAP_EN
        abc_blk = {32'h80636261, 448'h0, 32'h18000000};
`else
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
`endif
        for (int i = 0; i < 16; i++)
            pat_blk[511 - 32*i -: 32] = 32'h01020304 + 32'(i) * 32'h11111111;

        // Reset, with a block offered during reset that must not be taken.
        rst = 1'b1; block_valid_i = 1'b0; block_i = '0;
        tick();
        block_valid_i = 1'b1; block_i = abc_blk;
        tick();
        chk("rst_ready",   32'(block_ready_o), 32'h0);
        chk("rst_counter", 32'(counter_o), 32'h0);
        chk("rst_m",       M_o, 32'h0);
        chk("rst_wvalid",  32'(w_valid_o), 32'h0);
        chk("rst_windex",  32'(w_index_o), 32'h0);
        chk("rst_done",    32'(done_o), 32'h0);
        block_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(block_ready_o), 32'h1);
        tick();
        chk("no_accept_in_rst", 32'(w_valid_o), 32'h0);

        // "abc" block.
        run_block(abc_blk, 1'b1);

        // Idle for a while, then a new block 5 cycles after done.
        for (int k = 0; k < 4; k++) begin
            chk("idle_counter", 32'(counter_o), 32'h0);
            chk("idle_m",       M_o, 32'h0);
            chk("idle_wvalid",  32'(w_valid_o), 32'h0);
            tick();
        end
        run_block(pat_blk, 1'b0);

        // Two blocks back-to-back with valid held high.
        block_i = abc_blk;
        block_valid_i = 1'b1;
        tick();
        for (int k = 0; k <= 129; k++) begin
            if (k < 128) chk("b2b_counter", 32'(counter_o), 32'(k % 64));
            chk("b2b_wvalid", 32'(w_valid_o), 32'(k >= 1 && k <= 128));
            chk("b2b_done",   32'(done_o), 32'(k == 64 || k == 128));
            if (k == 0)  chk("b2b_m_first",  M_o, exp_word(abc_blk, 0));
            if (k == 64) chk("b2b_m_second", M_o, exp_word(pat_blk, 0));
            if (k == 65) chk("b2b_m_second1", M_o, exp_word(pat_blk, 1));
            if (k == 62) block_i = pat_blk;
            if (k == 64) block_valid_i = 1'b0;
            tick();
        end

        // Reset pulsed while W index 30 is on the output.
        block_i = abc_blk;
        block_valid_i = 1'b1;
        tick();
        block_valid_i = 1'b0;
        for (int k = 0; k < 31; k++) tick();
        chk("pre_rst_windex", 32'(w_index_o), 32'd30);
        rst = 1'b1;
        tick();
        chk("abort_wvalid",  32'(w_valid_o), 32'h0);
        chk("abort_done",    32'(done_o), 32'h0);
        chk("abort_counter", 32'(counter_o), 32'h0);
        chk("abort_m",       M_o, 32'h0);
        chk("abort_ready",   32'(block_ready_o), 32'h0);
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(block_ready_o), 32'h1);
        for (int k = 0; k < 40; k++) begin
            chk("abort_quiet_wvalid", 32'(w_valid_o), 32'h0);
            chk("abort_quiet_done",   32'(done_o), 32'h0);
            tick();
        end
        run_block(abc_blk, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
